// File: rtl/axi_hp_pkg.sv
// Shared constants and FSM state type for the HP0 write DMA.
// Imported by hp_wr_fifo and axi_hp_wr_dma.
package axi_hp_pkg;

  localparam int BURST_BEATS = 16;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [3:0] AXI_CACHE_BUF  = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } wr_state_t;

endpackage

// File: rtl/hp_wr_fifo.sv
// Synchronous first-word-fall-through FIFO with an occupancy count.
// Ports: clk, rst, wr_en/wr_data, rd_en/rd_data, full, count.
module hp_wr_fifo
  import axi_hp_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [31:0]                wr_data,
  input  logic                       rd_en,
  output logic [31:0]                rd_data,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  assign rd_data = mem[rp];
  assign full    = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wp] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_en)
        wp <= wp + 1'b1;
      if (rd_en)
        rp <= rp + 1'b1;
      // push and pop together leave the count unchanged
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/axi_hp_wr_dma.sv
// Streams 32-bit samples into a DDR ring buffer over AXI3 HP0 as 16-beat bursts.
// Ports: clk/rst, enable, ring config, sample stream, status, AXI AW/W/B.
module axi_hp_wr_dma
  import axi_hp_pkg::*;
#(
  parameter int         FIFO_DEPTH = 64,
  parameter logic [5:0] AXI_ID     = 6'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] base_addr,
  input  logic [23:0] buf_words,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [23:0] wr_ptr,
  output logic        overflow,
  output logic        bresp_err,
  output logic [31:0] m_awaddr,
  output logic [3:0]  m_awlen,
  output logic [5:0]  m_awid,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [1:0]  m_awburst,
  output logic [2:0]  m_awsize,
  output logic [3:0]  m_awcache,
  output logic [1:0]  m_awlock,
  output logic [2:0]  m_awprot,
  output logic [3:0]  m_awqos,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic [5:0]  m_wid,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [5:0]  m_bid,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] LAST_BEAT = 4'(BURST_BEATS - 1);
  localparam logic [23:0] STEP     = 24'(BURST_BEATS);

  wr_state_t   state;
  logic [3:0]  beat;
  logic [23:0] buf_q;
  logic [23:0] ptr_nxt;
  logic        rst_done;
  logic        full;
  logic        push;
  logic        pop;
  logic [CW-1:0] cnt;
  logic        bid_unused;

  // single outstanding burst, so the returned ID carries no information
  assign bid_unused = ^m_bid;

  assign m_awlen   = LAST_BEAT;
  assign m_awid    = AXI_ID;
  assign m_wid     = AXI_ID;
  assign m_awburst = AXI_BURST_INCR;
  assign m_awsize  = AXI_SIZE_4B;
  assign m_awcache = AXI_CACHE_BUF;
  assign m_awlock  = 2'b00;
  assign m_awprot  = 3'b000;
  assign m_awqos   = 4'b0000;
  assign m_wstrb   = 4'hF;

  // held low through reset and for the first edge after release
  assign s_ready = rst_done && !full;
  assign push    = enable && s_valid && s_ready;
  assign pop     = m_wvalid && m_wready;
  assign ptr_nxt = wr_ptr + STEP;

  hp_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (s_data),
    .rd_en   (pop),
    .rd_data (m_wdata),
    .full    (full),
    .count   (cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rst_done <= 1'b1;
      if (rst_done && enable && s_valid && !s_ready)
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      m_awvalid <= 1'b0;
      m_awaddr  <= '0;
      m_wvalid  <= 1'b0;
      m_wlast   <= 1'b0;
      m_bready  <= 1'b0;
      beat      <= '0;
      buf_q     <= '0;
      wr_ptr    <= '0;
      bresp_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable && cnt >= CW'(BURST_BEATS)) begin
            state     <= ADDR;
            m_awvalid <= 1'b1;
            m_awaddr  <= base_addr + {6'd0, wr_ptr, 2'b00};
            buf_q     <= buf_words;
          end
        end
        ADDR: begin
          if (m_awready) begin
            state     <= DATA;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b1;
            beat      <= '0;
          end
        end
        DATA: begin
          if (m_wready) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              state    <= RESP;
              m_wvalid <= 1'b0;
              m_wlast  <= 1'b0;
              m_bready <= 1'b1;
            end else begin
              m_wlast <= (beat == LAST_BEAT - 4'd1);
            end
          end
        end
        RESP: begin
          if (m_bvalid) begin
            state    <= IDLE;
            m_bready <= 1'b0;
            if (m_bresp != 2'b00)
              bresp_err <= 1'b1;
            wr_ptr <= (ptr_nxt == buf_q) ? '0 : ptr_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_hp_wr_dma.sv
// Self-checking bench for axi_hp_wr_dma: queue-based ring/FIFO model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_axi_hp_wr_dma;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b1;
  logic [31:0] base_addr = 32'h1000_0000;
  logic [23:0] buf_words = 24'd32;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [23:0] wr_ptr;
  logic        overflow, bresp_err;
  logic [31:0] m_awaddr;
  logic [3:0]  m_awlen;
  logic [5:0]  m_awid;
  logic        m_awvalid;
  logic        m_awready = 1'b1;
  logic [1:0]  m_awburst;
  logic [2:0]  m_awsize;
  logic [3:0]  m_awcache;
  logic [1:0]  m_awlock;
  logic [2:0]  m_awprot;
  logic [3:0]  m_awqos;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [5:0]  m_wid;
  logic        m_wlast, m_wvalid;
  logic        m_wready = 1'b1;
  logic [5:0]  m_bid = 6'd0;
  logic [1:0]  m_bresp = 2'b00;
  logic        m_bvalid = 1'b0;
  logic        m_bready;

  axi_hp_wr_dma dut (
    .clk(clk), .rst(rst), .enable(enable),
    .base_addr(base_addr), .buf_words(buf_words),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wr_ptr(wr_ptr), .overflow(overflow), .bresp_err(bresp_err),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awid(m_awid),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_awburst(m_awburst), .m_awsize(m_awsize), .m_awcache(m_awcache),
    .m_awlock(m_awlock), .m_awprot(m_awprot), .m_awqos(m_awqos),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wid(m_wid),
    .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
    .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model state ----------------
  logic [31:0] mq[$];
  int          mptr, beats, aw_cnt, b_cnt;
  bit          ovf_m, berr_m, aw_open;
  bit          wl_flag, bh_flag;
  bit          prev_awv, prev_awr, prev_en;
  int          prev_size;
  logic [23:0] last_ptr;
  bit          will_push;
  logic        alive;

  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];
  bit          wlast_log[$];
  int          ptr_log[$];

  // responder knobs
  bit          aw_hold = 0;
  bit          wtoggle = 0;
  logic [1:0]  bresp_val = 2'b00;

  // s_ready may rise only from the first edge after reset release
  always @(posedge clk or posedge rst)
    if (rst) alive <= 1'b0;
    else     alive <= 1'b1;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      mptr = 0; beats = 0; aw_cnt = 0; b_cnt = 0;
      ovf_m = 0; berr_m = 0; aw_open = 0;
      wl_flag = 0; bh_flag = 0;
      prev_awv = 0; prev_awr = 0; prev_en = 0; prev_size = 0;
      last_ptr = '0;
    end else begin
      if (wr_ptr !== last_ptr) begin
        ptr_log.push_back(int'(wr_ptr));
        last_ptr = wr_ptr;
      end
      chk("s_ready", s_ready, (alive && mq.size() < 64));
      chk("overflow", overflow, ovf_m);
      chk("bresp_err", bresp_err, berr_m);
      chk("wr_ptr", wr_ptr, mptr);
      chk("wvalid", m_wvalid, (aw_open && beats < 16));
      chk("bready", m_bready, (aw_open && beats == 16));
      if (prev_awv && !prev_awr)
        chk("awvalid_hold", m_awvalid, 1);
      if (m_awvalid) begin
        chk("aw_outstanding", aw_open, 0);
        chk("awaddr", m_awaddr, base_addr + 32'(4 * mptr));
        chk("awlen", m_awlen, 15);
        chk("awid", m_awid, 0);
        chk("aw_consts", {m_awburst, m_awsize, m_awcache,
                          m_awlock, m_awprot, m_awqos},
            {2'b01, 3'b010, 4'b0011, 2'b00, 3'b000, 4'b0000});
        if (!prev_awv)
          chk("aw_start_cond", (prev_en && prev_size >= 16), 1);
      end
      if (m_wvalid) begin
        chk("wdata", m_wdata, (mq.size() > 0) ? mq[0] : 32'hDEAD_BEEF);
        chk("wlast", m_wlast, (beats == 15));
        chk("wstrb_wid", {m_wstrb, m_wid}, {4'hF, 6'd0});
      end
      will_push = enable && s_valid && alive && mq.size() < 64;
      if (enable && s_valid && !(alive && mq.size() < 64))
        ovf_m = 1;
      if (m_awvalid && m_awready) begin
        aw_open = 1; beats = 0; aw_cnt++;
        aw_log.push_back(m_awaddr);
      end
      if (m_wvalid && m_wready) begin
        w_log.push_back(m_wdata);
        wlast_log.push_back(m_wlast);
        if (m_wlast) wl_flag = 1;
        if (mq.size() > 0) void'(mq.pop_front());
        beats++;
      end
      if (m_bvalid && m_bready) begin
        b_cnt++;
        if (m_bresp != 2'b00) berr_m = 1;
        mptr = (mptr + 16 == int'(buf_words)) ? 0 : mptr + 16;
        aw_open = 0;
        bh_flag = 1;
      end
      if (will_push) mq.push_back(s_data);
      prev_awv  = m_awvalid;
      prev_awr  = m_awready;
      prev_en   = enable;
      prev_size = mq.size();
    end
  end

  // AXI slave responder, driven just after each rising edge
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        m_bvalid = 0; m_awready = !aw_hold; m_wready = 1;
      end else begin
        m_awready = !aw_hold;
        m_wready  = wtoggle ? !m_wready : 1'b1;
        if (bh_flag) begin m_bvalid = 0; bh_flag = 0; end
        if (wl_flag) begin
          m_bvalid = 1; m_bresp = bresp_val; wl_flag = 0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    rst = 1; s_valid = 0; enable = 1;
    aw_hold = 0; wtoggle = 0; bresp_val = 2'b00;
    aw_log.delete(); w_log.delete(); wlast_log.delete(); ptr_log.delete();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] v);
    int t = 0;
    s_data = v; s_valid = 1;
    @(negedge clk);
    while (!s_ready && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
    s_valid = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    @(negedge clk);
    while (!((mq.size() < 16 || !enable) && !aw_open && !m_awvalid)
           && t < 3000) begin
      @(negedge clk); t++;
    end
    if (t >= 3000) chk("drain_timeout", 1, 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  int t;
  int nl;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_valids", {m_awvalid, m_wvalid, m_wlast, m_bready}, 4'b0);
    chk("rst_status", {overflow, bresp_err}, 2'b0);
    chk("rst_wr_ptr", wr_ptr, 0);
    rst = 0;
    #1 chk("s_ready_before_edge", s_ready, 0);
    @(posedge clk); #1;
    chk("s_ready_after_release", s_ready, 1);

    // three bursts around a 32-word ring
    for (int i = 0; i < 48; i++) send(32'(i));
    wait_done();
    chk("s1_aw_count", aw_log.size(), 3);
    if (aw_log.size() == 3) begin
      chk("s1_aw0", aw_log[0], 32'h1000_0000);
      chk("s1_aw1", aw_log[1], 32'h1000_0040);
      chk("s1_aw2", aw_log[2], 32'h1000_0000);
    end
    chk("s1_w_count", w_log.size(), 48);
    for (int i = 0; i < 48 && i < w_log.size(); i++)
      chk("s1_wdata_order", w_log[i], 32'(i));
    chk("s1_ptr_count", ptr_log.size(), 3);
    if (ptr_log.size() == 3) begin
      chk("s1_ptr0", ptr_log[0], 16);
      chk("s1_ptr1", ptr_log[1], 0);
      chk("s1_ptr2", ptr_log[2], 16);
    end

    // 15 samples start nothing; the 16th starts a burst promptly
    apply_reset();
    for (int i = 0; i < 15; i++) send(32'(100 + i));
    t = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (m_awvalid) t++;
    end
    chk("s2_no_aw_at_15", t, 0);
    send(32'd115);
    t = 0;
    while (!m_awvalid && t < 2) begin @(posedge clk); #1; t++; end
    chk("s2_aw_within_2", m_awvalid, 1);
    wait_done();
    chk("s2_wr_ptr", wr_ptr, 16);

    // wready toggling
    apply_reset();
    wtoggle = 1;
    for (int i = 0; i < 16; i++) send(32'(200 + i));
    wait_done();
    chk("s3_beats", w_log.size(), 16);
    nl = 0;
    foreach (wlast_log[i]) if (wlast_log[i]) nl++;
    chk("s3_wlast_count", nl, 1);
    if (wlast_log.size() == 16) chk("s3_wlast_on_16", wlast_log[15], 1);
    for (int i = 0; i < 16 && i < w_log.size(); i++)
      chk("s3_wdata", w_log[i], 32'(200 + i));

    // error response
    apply_reset();
    bresp_val = 2'b10;
    for (int i = 0; i < 16; i++) send(32'(300 + i));
    wait_done();
    chk("s4_bresp_err", bresp_err, 1);
    chk("s4_wr_ptr", wr_ptr, 16);

    // address channel stalled, FIFO fills and overflows
    apply_reset();
    aw_hold = 1;
    for (int i = 0; i < 16; i++) send(32'(400 + i));
    for (int i = 0; i < 64; i++) begin
      s_data = 32'(416 + i); s_valid = 1;
      @(posedge clk); #1;
    end
    s_valid = 0;
    @(posedge clk); #1;
    chk("s5_s_ready", s_ready, 0);
    chk("s5_overflow", overflow, 1);
    aw_hold = 0;
    wait_done();
    chk("s5_aw_count", aw_log.size(), 4);
    chk("s5_w_count", w_log.size(), 64);
    chk("s5_overflow_sticky", overflow, 1);

    // enable dropped mid-burst, then reset mid-DATA
    apply_reset();
    aw_hold = 1;
    for (int i = 0; i < 32; i++) send(32'(500 + i));
    aw_hold = 0;
    t = 0;
    while (!(aw_open && beats >= 5) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("s6_reached_beat5", (aw_open && beats >= 5), 1);
    enable = 0;
    wait_done();
    repeat (30) @(posedge clk);
    #1;
    chk("s6_aw_count", aw_cnt, 1);
    chk("s6_b_count", b_cnt, 1);
    chk("s6_wr_ptr", wr_ptr, 16);
    chk("s6_no_new_aw", m_awvalid, 0);
    enable = 1;
    t = 0;
    while (!(aw_open && beats >= 3) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("s6_reached_beat3", (aw_open && beats >= 3), 1);
    rst = 1;
    #1;
    chk("s6_rst_awvalid", m_awvalid, 0);
    chk("s6_rst_wvalid", m_wvalid, 0);
    chk("s6_rst_wlast", m_wlast, 0);
    chk("s6_rst_bready", m_bready, 0);
    chk("s6_rst_s_ready", s_ready, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("s6_post_rst_ptr", wr_ptr, 0);
    chk("s6_post_rst_ready", s_ready, 1);
    repeat (5) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
